// File: rtl/store_write_combine_buffer.sv
// rtl/store_write_combine_buffer.sv - line-merging store buffer between store retirement and the DCache write port
// Circular FIFO of line entries; cacheable stores merge into the youngest eligible same-line entry.
module store_write_combine_buffer #(
   parameter  int ENTRY_NUM  = 4,
   parameter  int LINE_BYTE  = 16,
   parameter  int ADDR_WIDTH = 32,
   parameter  int HIGH_WATER = 3,
   parameter  int AGE_LIMIT  = 15,
   parameter  int RETRY_WAIT = 4,
   localparam int OFF_W      = $clog2(LINE_BYTE),
   localparam int LINE_W     = ADDR_WIDTH - OFF_W,
   localparam int DATA_W     = LINE_BYTE * 8,
   localparam int CNT_W      = $clog2(ENTRY_NUM + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inValid,
   output logic                  inReady,
   input  logic                  inUncachable,
   input  logic [LINE_W-1:0]     inLineAddr,
   input  logic [DATA_W-1:0]     inData,
   input  logic [LINE_BYTE-1:0]  inByteWE,
   input  logic                  flush,
   output logic                  dcWriteReq,
   input  logic                  dcWriteReqAck,
   input  logic                  dcWriteHit,
   output logic [ADDR_WIDTH-1:0] dcWriteAddr,
   output logic [DATA_W-1:0]     dcWriteData,
   output logic [LINE_BYTE-1:0]  dcWriteByteWE,
   output logic                  dcWriteUncachable,
   output logic                  empty,
   output logic [CNT_W-1:0]      count
);
   localparam int PTR_W = $clog2(ENTRY_NUM);
   localparam int AGE_W = $clog2(AGE_LIMIT + 1);
   localparam int RTY_W = $clog2(RETRY_WAIT + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RETRY} state_t;

   state_t               state_q, state_d;
   logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [AGE_W-1:0]     age_q, age_d;
   logic [RTY_W-1:0]     retry_q, retry_d;
   logic                 valid_q [ENTRY_NUM];
   logic                 valid_d [ENTRY_NUM];
   logic                 unc_q   [ENTRY_NUM];
   logic                 unc_d   [ENTRY_NUM];
   logic [LINE_W-1:0]    line_q  [ENTRY_NUM];
   logic [LINE_W-1:0]    line_d  [ENTRY_NUM];
   logic [DATA_W-1:0]    data_q  [ENTRY_NUM];
   logic [DATA_W-1:0]    data_d  [ENTRY_NUM];
   logic [LINE_BYTE-1:0] we_q    [ENTRY_NUM];
   logic [LINE_BYTE-1:0] we_d    [ENTRY_NUM];

   logic             tgt_found, unc_seen, do_merge, do_alloc, do_pop, head_unc;
   logic [PTR_W-1:0] tgt_idx;

   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= ENTRY_NUM) s = s - ENTRY_NUM;
      return PTR_W'(s);
   endfunction

   // Walk youngest to oldest; an uncachable entry blocks merging into anything older.
   always_comb begin
      tgt_found = 1'b0;
      tgt_idx   = '0;
      unc_seen  = 1'b0;
      for (int k = ENTRY_NUM - 1; k >= 0; k--) begin
         if (valid_q[wrap_add(head_q, k)]) begin
            if (unc_q[wrap_add(head_q, k)]) begin
               unc_seen = 1'b1;
            end else if (!unc_seen && !tgt_found &&
                         line_q[wrap_add(head_q, k)] == inLineAddr &&
                         !(k == 0 && state_q != S_IDLE)) begin
               tgt_found = 1'b1;
               tgt_idx   = wrap_add(head_q, k);
            end
         end
      end
   end

   assign head_unc = unc_q[head_q];
   assign inReady  = !flush && ((tgt_found && !inUncachable) || (count_q < CNT_W'(ENTRY_NUM)));
   assign do_merge = inValid && inReady && tgt_found && !inUncachable;
   assign do_alloc = inValid && inReady && !do_merge;

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      do_pop  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0 && (count_q >= CNT_W'(HIGH_WATER) || flush || head_unc ||
                                  age_q >= AGE_W'(AGE_LIMIT)))
               state_d = S_REQ;
         end
         S_REQ: begin
            if (dcWriteReqAck) begin
               if (dcWriteHit || head_unc) begin
                  do_pop  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_RETRY;
                  retry_d = RTY_W'(RETRY_WAIT);
               end
            end
         end
         S_RETRY: begin
            retry_d = retry_q - RTY_W'(1);
            if (retry_q <= RTY_W'(1)) state_d = S_REQ;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      valid_d = valid_q;
      unc_d   = unc_q;
      line_d  = line_q;
      data_d  = data_q;
      we_d    = we_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (do_merge) begin
         for (int b = 0; b < LINE_BYTE; b++)
            if (inByteWE[b]) data_d[tgt_idx][b*8 +: 8] = inData[b*8 +: 8];
         we_d[tgt_idx] = we_q[tgt_idx] | inByteWE;
      end
      // Allocation only sees space that existed at the start of the cycle.
      if (do_alloc) begin
         valid_d[tail_q] = 1'b1;
         unc_d[tail_q]   = inUncachable;
         line_d[tail_q]  = inLineAddr;
         data_d[tail_q]  = inData;
         we_d[tail_q]    = inByteWE;
         tail_d          = wrap_add(tail_q, 1);
      end
      if (do_pop) begin
         valid_d[head_q] = 1'b0;
         head_d          = wrap_add(head_q, 1);
      end
      count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_pop);
      age_d   = age_q;
      if (do_pop || count_q == '0)
         age_d = '0;
      else if (state_q == S_IDLE && age_q < AGE_W'(AGE_LIMIT))
         age_d = age_q + AGE_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         age_q   <= '0;
         retry_q <= '0;
         for (int i = 0; i < ENTRY_NUM; i++) begin
            valid_q[i] <= 1'b0;
            unc_q[i]   <= 1'b0;
            line_q[i]  <= '0;
            data_q[i]  <= '0;
            we_q[i]    <= '0;
         end
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         age_q   <= age_d;
         retry_q <= retry_d;
         valid_q <= valid_d;
         unc_q   <= unc_d;
         line_q  <= line_d;
         data_q  <= data_d;
         we_q    <= we_d;
      end
   end

   assign dcWriteReq        = (state_q == S_REQ);
   assign dcWriteAddr       = dcWriteReq ? {line_q[head_q], {OFF_W{1'b0}}} : '0;
   assign dcWriteData       = dcWriteReq ? data_q[head_q] : '0;
   assign dcWriteByteWE     = dcWriteReq ? we_q[head_q] : '0;
   assign dcWriteUncachable = dcWriteReq ? unc_q[head_q] : 1'b0;
   assign count             = count_q;
   assign empty             = (count_q == '0);
endmodule

// File: tb/tb_store_write_combine_buffer.sv
// tb/tb_store_write_combine_buffer.sv - queue-model checked bench for store_write_combine_buffer
// Model predicts every cycle; directed scenarios add hand-computed literal expectations.
module tb_store_write_combine_buffer;
   localparam int N = 4, LB = 16, AW = 32, HW = 3, AGE = 15, RW = 4;
   localparam int LW = AW - 4, DW = LB * 8;

   logic          clk = 1'b0, rst = 1'b0;
   logic          inValid = 1'b0, inUncachable = 1'b0, flush = 1'b0;
   logic [LW-1:0] inLineAddr = '0;
   logic [DW-1:0] inData = '0;
   logic [LB-1:0] inByteWE = '0;
   logic          dcWriteReqAck = 1'b0, dcWriteHit = 1'b0;
   logic          inReady, dcWriteReq, dcWriteUncachable, empty;
   logic [AW-1:0] dcWriteAddr;
   logic [DW-1:0] dcWriteData;
   logic [LB-1:0] dcWriteByteWE;
   logic [2:0]    count;

   always #5 clk = ~clk;

   store_write_combine_buffer dut (
      .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
      .inUncachable(inUncachable), .inLineAddr(inLineAddr), .inData(inData),
      .inByteWE(inByteWE), .flush(flush), .dcWriteReq(dcWriteReq),
      .dcWriteReqAck(dcWriteReqAck), .dcWriteHit(dcWriteHit),
      .dcWriteAddr(dcWriteAddr), .dcWriteData(dcWriteData),
      .dcWriteByteWE(dcWriteByteWE), .dcWriteUncachable(dcWriteUncachable),
      .empty(empty), .count(count));

   typedef struct {
      logic          unc;
      logic [LW-1:0] line;
      logic [DW-1:0] data;
      logic [LB-1:0] we;
   } ent_t;

   ent_t mq[$];
   int   m_mode = 0;   // 0 idle, 1 requesting, 2 waiting to reissue
   int   m_age = 0, m_cyc = 0, m_resume = 0;
   int   n_assert = 0, n_fail = 0;
   int   u_sz, u_tgt, u_mode, c_tgt, npop;
   bit   u_rdy, u_pop;
   ent_t e;
   logic [AW-1:0] pops [8];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Eligible entries are those younger than the youngest uncachable one (and not a busy head).
   function automatic int m_target(input logic [LW-1:0] la);
      int lo;
      lo = (m_mode != 0) ? 1 : 0;
      for (int j = 0; j < mq.size(); j++)
         if (mq[j].unc && j + 1 > lo) lo = j + 1;
      for (int j = lo; j < mq.size(); j++)
         if (mq[j].line == la) return j;
      return -1;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         m_mode = 0;
         m_age  = 0;
      end else begin
         u_sz  = mq.size();
         u_tgt = inUncachable ? -1 : m_target(inLineAddr);
         u_rdy = !flush && (u_tgt >= 0 || u_sz < N);
         u_pop = (m_mode == 1) && dcWriteReqAck && (dcWriteHit || mq[0].unc);
         u_mode = m_mode;
         if (m_mode == 0) begin
            if (u_sz > 0 && (u_sz >= HW || flush || mq[0].unc || m_age >= AGE)) u_mode = 1;
         end else if (m_mode == 1) begin
            if (dcWriteReqAck) begin
               u_mode = u_pop ? 0 : 2;
               if (!u_pop) m_resume = m_cyc + RW;
            end
         end else if (m_cyc == m_resume) begin
            u_mode = 1;
         end
         if (u_pop || u_sz == 0) m_age = 0;
         else if (m_mode == 0 && m_age < AGE) m_age++;
         if (inValid && u_rdy) begin
            if (u_tgt >= 0) begin
               e = mq[u_tgt];
               for (int b = 0; b < LB; b++)
                  if (inByteWE[b]) e.data[b*8 +: 8] = inData[b*8 +: 8];
               e.we = e.we | inByteWE;
               mq[u_tgt] = e;
            end else begin
               e.unc = inUncachable; e.line = inLineAddr; e.data = inData; e.we = inByteWE;
               mq.push_back(e);
            end
         end
         if (u_pop) void'(mq.pop_front());
         m_mode = u_mode;
      end
      m_cyc++;
   end

   always @(negedge clk) begin
      #2;
      if (!rst) begin
         check("rst_req", DW'(dcWriteReq), DW'(0));
         check("rst_count", DW'(count), DW'(0));
         check("rst_empty", DW'(empty), DW'(1));
         check("rst_addr", DW'(dcWriteAddr), DW'(0));
      end else begin
         c_tgt = inUncachable ? -1 : m_target(inLineAddr);
         check("inReady", DW'(inReady), DW'(!flush && (c_tgt >= 0 || mq.size() < N)));
         check("count", DW'(count), DW'(mq.size()));
         check("empty", DW'(empty), DW'(mq.size() == 0));
         check("req", DW'(dcWriteReq), DW'(m_mode == 1));
         if (m_mode == 1 && mq.size() > 0) begin
            check("addr", DW'(dcWriteAddr), DW'({mq[0].line, 4'h0}));
            check("data", dcWriteData, mq[0].data);
            check("byteWE", DW'(dcWriteByteWE), DW'(mq[0].we));
            check("uncachable", DW'(dcWriteUncachable), DW'(mq[0].unc));
         end else begin
            check("idle_addr", DW'(dcWriteAddr), DW'(0));
            check("idle_byteWE", DW'(dcWriteByteWE), DW'(0));
         end
      end
   end

   task automatic drive(input logic v, input logic u, input logic [LW-1:0] la, input logic [DW-1:0] d,
                        input logic [LB-1:0] we, input logic fl, input logic ack, input logic hit);
      @(negedge clk);
      inValid = v; inUncachable = u; inLineAddr = la; inData = d; inByteWE = we;
      flush = fl; dcWriteReqAck = ack; dcWriteHit = hit;
   endtask

   task automatic wait_req(input logic fl, input int max, output int n);
      n = 0;
      for (int i = 1; i <= max; i++) begin
         drive(0, 0, '0, '0, '0, fl, 0, 0);
         #3;
         if (dcWriteReq) begin
            n = i;
            return;
         end
      end
      n_assert++; n_fail++;
      $display("FAIL wait_req: no request within %0d cycles", max);
   endtask

   task automatic drain(input logic fl, input int max);
      npop = 0;
      for (int i = 0; i < max; i++) begin
         drive(0, 0, '0, '0, '0, fl, 1, 1);
         #3;
         if (dcWriteReq) begin
            if (npop < 8) pops[npop] = dcWriteAddr;
            npop++;
         end else if (empty) begin
            return;
         end
      end
      n_assert++; n_fail++;
      $display("FAIL drain: buffer not empty within %0d cycles", max);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int n, gap;
   logic [DW-1:0] held_data;

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #3;
      check("lit_reset_count", DW'(count), DW'(0));
      check("lit_reset_empty", DW'(empty), DW'(1));
      check("lit_reset_ready", DW'(inReady), DW'(1));
      check("lit_reset_req", DW'(dcWriteReq), DW'(0));

      // High-water drain in FIFO order
      drive(1, 0, 28'h10, {4{32'h1111_0000}}, 16'hFFFF, 0, 0, 0);
      drive(1, 0, 28'h11, {4{32'h2222_0000}}, 16'hFFFF, 0, 0, 0);
      drive(1, 0, 28'h12, {4{32'h3333_0000}}, 16'hFFFF, 0, 0, 0);
      drive(0, 0, '0, '0, '0, 0, 0, 0);
      #3;
      check("lit_hw_count", DW'(count), DW'(3));
      wait_req(0, 5, n);
      check("lit_hw_latency", DW'(n), DW'(1));
      check("lit_hw_addr", DW'(dcWriteAddr), DW'(32'h100));
      drain(0, 100);
      check("lit_hw_npop", DW'(npop), DW'(3));
      check("lit_hw_pop1", DW'(pops[1]), DW'(32'h110));
      check("lit_hw_pop2", DW'(pops[2]), DW'(32'h120));
      check("lit_hw_empty", DW'(empty), DW'(1));

      // Merge plus age-forced drain
      drive(1, 0, 28'h20, 128'hAAAAAAAA, 16'h000F, 0, 0, 0);
      drive(1, 0, 28'h20, 128'hBBBBBBBB_00000000, 16'h00F0, 0, 0, 0);
      drive(0, 0, '0, '0, '0, 0, 0, 0);
      #3;
      check("lit_merge_count", DW'(count), DW'(1));
      wait_req(0, 30, n);
      check("lit_age_wait", DW'(n), DW'(15));
      check("lit_merge_we", DW'(dcWriteByteWE), DW'(16'h00FF));
      check("lit_merge_data", dcWriteData, 128'hBBBBBBBB_AAAAAAAA);
      drain(0, 20);
      check("lit_merge_npop", DW'(npop), DW'(1));

      // Full buffer: only a non-head merge is accepted
      for (int i = 0; i < 4; i++)
         drive(1, 0, 28'h50 + LW'(i), DW'(i + 1), 16'hFFFF, 0, 0, 0);
      drive(1, 0, 28'h54, 128'h5, 16'hFFFF, 0, 0, 0);
      #3;
      check("lit_full_ready", DW'(inReady), DW'(0));
      check("lit_full_count", DW'(count), DW'(4));
      drive(1, 0, 28'h50, 128'h6, 16'hFFFF, 0, 0, 0);
      #3;
      check("lit_busy_head_ready", DW'(inReady), DW'(0));
      drive(1, 0, 28'h52, 128'hCC, 16'h0001, 0, 0, 0);
      #3;
      check("lit_full_merge_ready", DW'(inReady), DW'(1));
      drive(0, 0, '0, '0, '0, 0, 0, 0);
      #3;
      check("lit_full_merge_count", DW'(count), DW'(4));
      drain(1, 200);
      check("lit_full_npop", DW'(npop), DW'(4));
      check("lit_full_pop3", DW'(pops[3]), DW'(32'h530));

      // Uncachable ordering
      drive(1, 1, 28'h30, 128'h77, 16'hFFFF, 0, 0, 0);
      drive(1, 0, 28'h30, 128'h88, 16'hFFFF, 0, 0, 0);
      drive(0, 0, '0, '0, '0, 0, 0, 0);
      #3;
      check("lit_unc_req", DW'(dcWriteReq), DW'(1));
      check("lit_unc_flag", DW'(dcWriteUncachable), DW'(1));
      check("lit_unc_addr", DW'(dcWriteAddr), DW'(32'h300));
      check("lit_unc_count", DW'(count), DW'(2));
      drive(0, 0, '0, '0, '0, 0, 1, 0);
      drive(0, 0, '0, '0, '0, 0, 0, 0);
      #3;
      check("lit_unc_pop_count", DW'(count), DW'(1));
      drain(0, 40);
      check("lit_unc_tail_pop", DW'(pops[0]), DW'(32'h300));

      // Miss and retry
      drive(1, 0, 28'h40, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 16'hFFFF, 0, 0, 0);
      wait_req(1, 5, n);
      held_data = dcWriteData;
      drive(0, 0, '0, '0, '0, 1, 1, 0);
      gap = 0;
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, '0, '0, '0, 1, 0, 0);
         #3;
         if (dcWriteReq) break;
         gap++;
      end
      check("lit_retry_gap", DW'(gap), DW'(RW));
      check("lit_retry_data", dcWriteData, held_data);
      check("lit_retry_addr", DW'(dcWriteAddr), DW'(32'h400));
      drive(0, 0, '0, '0, '0, 1, 1, 1);
      drive(0, 0, '0, '0, '0, 0, 0, 0);
      #3;
      check("lit_retry_empty", DW'(empty), DW'(1));

      // Flush drain, then reset during a request
      drive(1, 0, 28'h60, 128'h60, 16'hFFFF, 0, 0, 0);
      drive(1, 0, 28'h61, 128'h61, 16'hFFFF, 0, 0, 0);
      drive(1, 0, 28'h62, 128'h62, 16'hFFFF, 1, 0, 0);
      #3;
      check("lit_flush_ready", DW'(inReady), DW'(0));
      drain(1, 50);
      check("lit_flush_npop", DW'(npop), DW'(2));
      check("lit_flush_pop1", DW'(pops[1]), DW'(32'h610));
      drive(1, 0, 28'h70, 128'h70, 16'hFFFF, 0, 0, 0);
      drive(1, 0, 28'h71, 128'h71, 16'hFFFF, 0, 0, 0);
      wait_req(1, 5, n);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("lit_arst_req", DW'(dcWriteReq), DW'(0));
      check("lit_arst_count", DW'(count), DW'(0));
      check("lit_arst_empty", DW'(empty), DW'(1));
      @(negedge clk);
      flush = 1'b0; inValid = 1'b0;
      rst = 1'b1;
      #3;
      check("lit_post_rst_ready", DW'(inReady), DW'(1));
      repeat (3) drive(0, 0, '0, '0, '0, 0, 1, 1);
      #3;
      check("lit_post_rst_idle", DW'(dcWriteReq), DW'(0));
      drive(0, 0, '0, '0, '0, 0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
